// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: accumulator state
// encoding, the default lane width and the byte-keep mask helper.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned MAX_LANES  = 8;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_FLUSH = 2'd2
  } acc_state_t;

  // Keep mask with the low 'cnt' lanes set; cnt >= MAX_LANES gives all ones.
  function automatic logic [MAX_LANES-1:0] mk_keep(input logic [3:0] cnt);
    logic [MAX_LANES-1:0] one;
    one = {{(MAX_LANES-1){1'b0}}, 1'b1};
    if (cnt >= 4'd8) begin
      return '1;
    end
    return (one << cnt) - one;
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// Valid/ready output holding register. A load is only issued while 'free'
// is high, so a held word is never overwritten before it is accepted.
module fifo_out_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = 4
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              free
);

  assign free = !out_valid || out_ready;

  // Hold the word until accepted; a load in the accept cycle replaces it.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_keep  <= in_keep;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_read_packer.sv
// Read-domain FIFO consumer: pops bytes, packs BYTES_PER_WORD of them
// little-endian into one word and emits it on a valid/ready stream. A flush
// pulse emits the current partial word with a keep mask.
module fifo_read_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                             rclk,
  input  logic                             rrst_n,
  input  logic                             fifo_empty,
  output logic                             fifo_read_en,
  input  logic [DATA_W-1:0]                fifo_read_data,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]        out_keep,
  output logic                             busy
);

  localparam int unsigned N     = BYTES_PER_WORD;
  localparam int unsigned CW    = $clog2(N + 1);
  localparam int unsigned WW    = DATA_W * N;
  localparam logic [CW:0] N_EXT = (CW+1)'(N);

  if (READ_LATENCY != 1) begin : g_bad_latency
    $error("fifo_read_packer: READ_LATENCY must be 1");
  end
  if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > MAX_LANES) begin : g_bad_lanes
    $error("fifo_read_packer: BYTES_PER_WORD must be 2..8");
  end

  acc_state_t              state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic                    inflight_q;
  logic                    flush_pend_q, flush_pend_d;
  logic [N-1:0][DATA_W-1:0] acc_q;
  logic                    load;
  logic                    out_free;
  logic [CW:0]             fill_lvl;
  logic [N-1:0]            keep_w;

  // Bytes held plus the one still arriving; bounds fetching to one word.
  assign fill_lvl     = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
  assign fifo_read_en = !fifo_empty && !flush_pend_q && (fill_lvl < N_EXT);
  assign keep_w       = N'(mk_keep(4'(cnt_q)));
  assign busy         = (cnt_q != '0) || inflight_q || flush_pend_q;

  // State and flush-pending registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= S_FILL;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state and load decision. A flush landing together with the final
  // byte, or arriving while full, is satisfied by the full-word load.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    load         = 1'b0;
    case (state_q)
      S_FILL: begin
        if (flush) begin
          state_d      = S_FLUSH;
          flush_pend_d = 1'b1;
        end else if (inflight_q && (fill_lvl == N_EXT)) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (out_free) begin
          load         = 1'b1;
          state_d      = S_FILL;
          flush_pend_d = 1'b0;
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (!inflight_q) begin
          if (cnt_q == '0) begin
            state_d      = S_FILL;
            flush_pend_d = 1'b0;
          end else if (out_free) begin
            load         = 1'b1;
            state_d      = S_FILL;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: begin
        state_d      = S_FILL;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  // Pop tracking, byte capture into lane cnt, and clear on load.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
    end else begin
      inflight_q <= fifo_read_en;
      if (load) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (inflight_q) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) begin
            acc_q[i] <= fifo_read_data;
          end
        end
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  fifo_out_reg #(
    .DATA_W (WW),
    .KEEP_W (N)
  ) u_out_reg (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .load      (load),
    .in_data   (acc_q),
    .in_keep   (keep_w),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .free      (out_free)
  );

endmodule
